// File: rtl/sam_pkg.sv
// Shared types and constants for the SAM serial stimulus transmitter.
package sam_pkg;
  localparam int N_W   = 4;
  localparam int CNT_W = 5;

  localparam int DEF_ONE_HI  = 12;
  localparam int DEF_ONE_LO  = 6;
  localparam int DEF_ZERO_HI = 6;
  localparam int DEF_ZERO_LO = 12;
  localparam int DEF_GAP     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_LEAD,
    ST_CFG_SHIFT,
    ST_CFG_TAIL,
    ST_GAP,
    ST_READY,
    ST_BIT_HI,
    ST_BIT_LO
  } sam_state_e;
endpackage

// File: rtl/sam_pw_bit.sv
// Pulse-width bit encoder: one high phase then one low phase, lengths picked by bit value.
module sam_pw_bit
  import sam_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_val,
  input  logic [CNT_W-1:0] one_hi,
  input  logic [CNT_W-1:0] one_lo,
  input  logic [CNT_W-1:0] zero_hi,
  input  logic [CNT_W-1:0] zero_lo,
  output logic             str_bit,
  output logic             hi_done,
  output logic             done
);
  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lo_len;

  // Both strobes flag the last cycle of their phase so a new bit can start back to back.
  assign hi_done = active &  str_bit & (cnt == CNT_W'(1));
  assign done    = active & ~str_bit & (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active  <= 1'b0;
      str_bit <= 1'b0;
      cnt     <= '0;
      lo_len  <= '0;
    end else if (start) begin
      active  <= 1'b1;
      str_bit <= 1'b1;
      cnt     <= bit_val ? one_hi : zero_hi;
      lo_len  <= bit_val ? one_lo : zero_lo;
    end else if (hi_done) begin
      str_bit <= 1'b0;
      cnt     <= lo_len;
    end else if (done) begin
      active  <= 1'b0;
    end else if (active) begin
      cnt     <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/sam_str_tx.sv
// SAM stimulus transmitter: shifts n/d/N under mode=1, then sends pulse-width coded messages.
module sam_str_tx
  import sam_pkg::*;
#(
  parameter int KEY_LEN = 8,
  parameter int MSG_W   = 16,
  parameter int ONE_HI  = DEF_ONE_HI,
  parameter int ONE_LO  = DEF_ONE_LO,
  parameter int ZERO_HI = DEF_ZERO_HI,
  parameter int ZERO_LO = DEF_ZERO_LO,
  parameter int GAP     = DEF_GAP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic [N_W-1:0]     cfg_n,
  input  logic [KEY_LEN-1:0] cfg_d,
  input  logic [KEY_LEN-1:0] cfg_N,
  input  logic               msg_valid,
  input  logic [MSG_W-1:0]   msg_data,
  output logic               msg_ready,
  output logic               mode,
  output logic               str,
  output logic               busy,
  output logic               configured
);
  localparam int SHIFT_LEN = N_W + 2*KEY_LEN;
  localparam int SH_W      = $clog2(SHIFT_LEN + 1);
  localparam int GAP_W     = $clog2(GAP + 1);
  localparam int DUR_MAX   = (1 << CNT_W) - 1;

  if (ONE_HI < 1 || ONE_HI > DUR_MAX || ONE_LO < 1 || ONE_LO > DUR_MAX ||
      ZERO_HI < 1 || ZERO_HI > DUR_MAX || ZERO_LO < 1 || ZERO_LO > DUR_MAX) begin : g_bad_dur
    $error("sam_str_tx: bit durations must lie in 1..%0d", DUR_MAX);
  end
  if (ONE_HI <= ONE_LO || ZERO_LO <= ZERO_HI) begin : g_bad_code
    $error("sam_str_tx: need ONE_HI > ONE_LO and ZERO_LO > ZERO_HI");
  end
  if (GAP < 1 || GAP > DUR_MAX) begin : g_bad_gap
    $error("sam_str_tx: GAP must lie in 1..%0d", DUR_MAX);
  end
  if (MSG_W < (1 << N_W) - 1) begin : g_bad_msgw
    $error("sam_str_tx: MSG_W too narrow for the largest n");
  end

  sam_state_e         state;
  logic [N_W-1:0]     n_q;
  logic [KEY_LEN-1:0] d_q;
  logic [KEY_LEN-1:0] nn_q;
  logic [SHIFT_LEN-1:0] cfg_sr;
  logic [SH_W-1:0]    sh_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [MSG_W-1:0]   msg_sr;
  logic [N_W-1:0]     bit_cnt;
  logic               str_cfg;

  logic               hs;
  logic [MSG_W-1:0]   aligned;
  logic               pw_start;
  logic               pw_bit;
  logic               str_bit;
  logic               hi_done;
  logic               done;

  assign msg_ready = (state == ST_READY);
  assign hs        = msg_ready & msg_valid & ~cfg_start;

  // Left-align bit n-1 at the MSB; zeros shifted in behind it supply the trailer bit.
  assign aligned   = msg_data << (MSG_W - int'(n_q));
  assign pw_start  = hs | ((state == ST_BIT_LO) & done & (bit_cnt != '0));
  assign pw_bit    = hs ? aligned[MSG_W-1] : msg_sr[MSG_W-1];

  // Only one of the two flops is ever nonzero, so the OR never glitches high.
  assign str = str_cfg | str_bit;

  sam_pw_bit u_pw (
    .clk     (clk),
    .reset   (reset),
    .start   (pw_start),
    .bit_val (pw_bit),
    .one_hi  (CNT_W'(ONE_HI)),
    .one_lo  (CNT_W'(ONE_LO)),
    .zero_hi (CNT_W'(ZERO_HI)),
    .zero_lo (CNT_W'(ZERO_LO)),
    .str_bit (str_bit),
    .hi_done (hi_done),
    .done    (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      n_q        <= '0;
      d_q        <= '0;
      nn_q       <= '0;
      cfg_sr     <= '0;
      sh_cnt     <= '0;
      gap_cnt    <= '0;
      msg_sr     <= '0;
      bit_cnt    <= '0;
      str_cfg    <= 1'b0;
      mode       <= 1'b0;
      busy       <= 1'b0;
      configured <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_READY: begin
          if (cfg_start) begin
            n_q   <= cfg_n;
            d_q   <= cfg_d;
            nn_q  <= cfg_N;
            mode  <= 1'b1;
            busy  <= 1'b1;
            state <= ST_CFG_LEAD;
          end else if (hs) begin
            msg_sr  <= aligned << 1;
            bit_cnt <= n_q;
            busy    <= 1'b1;
            state   <= ST_BIT_HI;
          end
        end
        ST_CFG_LEAD: begin
          str_cfg <= n_q[N_W-1];
          cfg_sr  <= {n_q, d_q, nn_q} << 1;
          sh_cnt  <= SH_W'(SHIFT_LEN - 1);
          state   <= ST_CFG_SHIFT;
        end
        ST_CFG_SHIFT: begin
          if (sh_cnt == '0) begin
            str_cfg <= 1'b0;
            state   <= ST_CFG_TAIL;
          end else begin
            str_cfg <= cfg_sr[SHIFT_LEN-1];
            cfg_sr  <= cfg_sr << 1;
            sh_cnt  <= sh_cnt - 1'b1;
          end
        end
        ST_CFG_TAIL: begin
          mode    <= 1'b0;
          gap_cnt <= GAP_W'(GAP);
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            busy       <= 1'b0;
            configured <= 1'b1;
            state      <= ST_READY;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_BIT_HI: begin
          if (hi_done) state <= ST_BIT_LO;
        end
        ST_BIT_LO: begin
          if (done) begin
            if (bit_cnt != '0) begin
              msg_sr  <= msg_sr << 1;
              bit_cnt <= bit_cnt - 1'b1;
              state   <= ST_BIT_HI;
            end else begin
              gap_cnt <= GAP_W'(GAP);
              state   <= ST_GAP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sam_str_tx.sv
// Randomized bench for sam_str_tx against a waveform-level model of the link.
module tb_sam_str_tx;
  localparam int K  = 8;
  localparam int MW = 16;
  localparam int OH = 12, OL = 6, ZH = 6, ZL = 12, G = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic [3:0]    cfg_n = '0;
  logic [K-1:0]  cfg_d = '0;
  logic [K-1:0]  cfg_N = '0;
  logic          msg_valid = 1'b0;
  logic [MW-1:0] msg_data = '0;
  logic          msg_ready, mode, str, busy, configured;

  int vecs = 0;
  int errs = 0;
  bit exp_str[$];
  bit exp_mode[$];

  sam_str_tx dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_n(cfg_n),
    .cfg_d(cfg_d), .cfg_N(cfg_N), .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_ready(msg_ready), .mode(mode), .str(str), .busy(busy),
    .configured(configured)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected (mode,str) per cycle from the cycle after cfg_start is sampled.
  function automatic void model_cfg(logic [3:0] n, logic [K-1:0] d, logic [K-1:0] nn);
    exp_str.delete(); exp_mode.delete();
    exp_mode.push_back(1); exp_str.push_back(0);
    for (int i = 3; i >= 0; i--)   begin exp_mode.push_back(1); exp_str.push_back(n[i]);  end
    for (int i = K-1; i >= 0; i--) begin exp_mode.push_back(1); exp_str.push_back(d[i]);  end
    for (int i = K-1; i >= 0; i--) begin exp_mode.push_back(1); exp_str.push_back(nn[i]); end
    exp_mode.push_back(1); exp_str.push_back(0);
    for (int i = 0; i < G; i++)    begin exp_mode.push_back(0); exp_str.push_back(0); end
  endfunction

  function automatic void push_bit(bit b);
    for (int i = 0; i < (b ? OH : ZH); i++) exp_str.push_back(1);
    for (int i = 0; i < (b ? OL : ZL); i++) exp_str.push_back(0);
  endfunction

  // Expected str per cycle from the cycle after the handshake until READY returns.
  function automatic void model_msg(int n, logic [MW-1:0] data);
    exp_str.delete();
    for (int i = n-1; i >= 0; i--) push_bit(data[i]);
    push_bit(0);
    for (int i = 0; i < G; i++) exp_str.push_back(0);
  endfunction

  task automatic run_cfg(input string tag, input logic [3:0] n, input logic [K-1:0] d,
                         input logic [K-1:0] nn, input bit with_valid);
    model_cfg(n, d, nn);
    cfg_n = n; cfg_d = d; cfg_N = nn; cfg_start = 1'b1;
    if (with_valid) begin msg_valid = 1'b1; msg_data = 16'($urandom); end
    @(posedge clk); @(negedge clk);
    cfg_start = 1'b0; msg_valid = 1'b0;
    for (int i = 0; i < exp_str.size(); i++) begin
      vecs++;
      if (mode !== exp_mode[i] || str !== exp_str[i] || msg_ready !== 1'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL %s cfg cycle %0d: mode,str,rdy,busy=%b%b%b%b want %b%b01",
                 tag, i, mode, str, msg_ready, busy, exp_mode[i], exp_str[i]);
      end
      @(negedge clk);
    end
    vecs++;
    if (configured !== 1'b1 || msg_ready !== 1'b1 || busy !== 1'b0 || mode !== 1'b0 || str !== 1'b0) begin
      errs++;
      $display("FAIL %s cfg end: cfgd,rdy,busy,mode,str=%b%b%b%b%b want 11000",
               tag, configured, msg_ready, busy, mode, str);
    end
  endtask

  task automatic run_msg(input string tag, input int n, input logic [MW-1:0] data, output int lat);
    int c;
    model_msg(n, data);
    vecs++;
    if (msg_ready !== 1'b1) begin
      errs++; $display("FAIL %s pre-send ready: got %b want 1", tag, msg_ready);
    end
    msg_valid = 1'b1; msg_data = data;
    @(posedge clk); @(negedge clk);
    msg_valid = 1'b0; msg_data = 16'($urandom);
    c = 0;
    while (c < 600 && msg_ready !== 1'b1) begin
      vecs++;
      if (c >= exp_str.size() || str !== exp_str[c] || mode !== 1'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL %s msg cycle %0d: str,mode,busy=%b%b%b want %b01", tag, c, str, mode, busy,
                 (c < exp_str.size()) ? exp_str[c] : 1'b0);
      end
      c++;
      @(negedge clk);
    end
    lat = c;
    vecs++;
    if (c != exp_str.size() || str !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s ready latency: got %0d cycles str=%b busy=%b want %0d cycles str=0 busy=0",
               tag, c, str, busy, exp_str.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({mode, str, busy, msg_ready, configured} !== 5'b0) begin
      errs++; $display("FAIL reset_held: outs=%b want 00000", {mode, str, busy, msg_ready, configured});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({mode, str, busy, msg_ready, configured} !== 5'b0) begin
      errs++; $display("FAIL reset_idle: outs=%b want 00000", {mode, str, busy, msg_ready, configured});
    end
  endtask

  task automatic test_unconfigured(input string tag, input int cycles);
    msg_valid = 1'b1; msg_data = 16'hFFFF;
    for (int c = 0; c < cycles; c++) begin
      vecs++;
      if (msg_ready !== 1'b0 || str !== 1'b0 || busy !== 1'b0 || configured !== 1'b0) begin
        errs++;
        $display("FAIL %s cycle %0d: rdy,str,busy,cfgd=%b%b%b%b want 0000", tag, c, msg_ready, str, busy, configured);
      end
      @(negedge clk);
    end
    msg_valid = 1'b0;
  endtask

  task automatic test_config();
    logic [19:0] sh;
    logic [19:0] want;
    int mhi;
    want = 20'b0011_10100101_00111100;
    sh = '0; mhi = 0;
    cfg_n = 4'd3; cfg_d = 8'hA5; cfg_N = 8'h3C; cfg_start = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_start = 1'b0;
    for (int c = 0; c < 22 + G; c++) begin
      if (mode === 1'b1) mhi++;
      if (c >= 1 && c <= 20) sh = {sh[18:0], str};
      if (c == 0 || c == 21 || c >= 22) begin
        vecs++;
        if (str !== 1'b0 || configured !== 1'b0) begin
          errs++; $display("FAIL cfg_fixed idle str cycle %0d: str=%b cfgd=%b want 0 0", c, str, configured);
        end
      end
      @(negedge clk);
    end
    vecs++;
    if (sh !== want) begin
      errs++; $display("FAIL cfg_fixed bits: got %b want %b", sh, want);
    end
    vecs++;
    if (mhi != 22) begin
      errs++; $display("FAIL cfg_fixed mode width: got %0d want 22", mhi);
    end
    vecs++;
    if (configured !== 1'b1 || msg_ready !== 1'b1) begin
      errs++; $display("FAIL cfg_fixed done: cfgd=%b rdy=%b want 1 1", configured, msg_ready);
    end
  endtask

  task automatic test_msg_101();
    int lat;
    run_msg("msg_101", 3, 16'hA5A5, lat);
    vecs++;
    if (lat != 74) begin
      errs++; $display("FAIL msg_101 latency: got %0d want 74", lat);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] n;
    for (int r = 0; r < 2; r++) begin
      n = 4'($urandom_range(1, 15));
      run_cfg("rand_cfg", n, 8'($urandom), 8'($urandom), 1'b0);
      for (int m = 0; m < 4; m++) run_msg("rand_msg", int'(n), 16'($urandom), lat);
    end
  endtask

  task automatic test_n0();
    int lat;
    run_cfg("n0_cfg", 4'd0, 8'($urandom), 8'($urandom), 1'b0);
    run_msg("n0_msg", 0, 16'hFFFF, lat);
    vecs++;
    if (lat != ZH + ZL + G) begin
      errs++; $display("FAIL n0 latency: got %0d want %0d", lat, ZH + ZL + G);
    end
  endtask

  task automatic test_cfg_wins();
    int lat;
    run_cfg("cfg_wins", 4'd5, 8'h5A, 8'hC3, 1'b1);
    run_msg("cfg_wins_msg", 5, 16'($urandom), lat);
  endtask

  task automatic test_reset_mid();
    msg_valid = 1'b1; msg_data = 16'hFFFF;
    @(posedge clk); @(negedge clk);
    msg_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (str !== 1'b1 || configured !== 1'b1) begin
      errs++; $display("FAIL rst_mid precondition: str=%b cfgd=%b want 1 1", str, configured);
    end
    #2 reset = 1'b0;
    #1;
    vecs++;
    if ({mode, str, busy, msg_ready, configured} !== 5'b0) begin
      errs++; $display("FAIL rst_mid async: outs=%b want 00000", {mode, str, busy, msg_ready, configured});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_unconfigured("rst_mid_after", 50);
  endtask

  initial begin
    test_reset();
    test_unconfigured("unconfigured", 100);
    test_config();
    test_msg_101();
    test_random();
    test_n0();
    test_cfg_wins();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/sam_str_tx.md
# sam_str_tx

Serial stimulus transmitter for the SAM decryption receiver: drives the `mode`/`str` pair that SAM samples. In configuration it shifts n, d and N onto `str` one bit per clock, MSB first, under `mode`=1. In message phase it emits n-bit messages in pulse-width code: each bit is a high phase followed by a low phase, and the bit value is 1 when the high phase is longer. It is the transmit end of the same link, used by system benches and by the board-level message source.

## Interface
Parameters:
- KEY_LEN, 8: width of d and N in bits.
- MSG_W, 16: width of `msg_data`; n ≤ 15 always fits.
- ONE_HI, 12: high cycles of an encoded 1.
- ONE_LO, 6: low cycles of an encoded 1.
- ZERO_HI, 6: high cycles of an encoded 0.
- ZERO_LO, 12: low cycles of an encoded 0.
- GAP, 2: forced-low cycles after configuration and after each message.

Ports:
- clk, in, 1: single clock; all state changes on posedge.
- reset, in, 1: asynchronous, active-low.
- cfg_start, in, 1: one-cycle request to configure; samples cfg_n, cfg_d, cfg_N.
- cfg_n, in, 4: message length n.
- cfg_d, in, KEY_LEN: key d.
- cfg_N, in, KEY_LEN: modulus N.
- msg_valid, in, 1: message offered.
- msg_data, in, MSG_W: message; bits [n-1:0] are sent, bit n-1 first.
- msg_ready, out, 1: message accepted when valid and ready are both 1.
- mode, out, 1: configuration strobe to SAM.
- str, out, 1: serial line to SAM.
- busy, out, 1: 1 while configuring, sending, or in a gap.
- configured, out, 1: set after the first completed configuration.

## Operation
- Reset values: mode=0, str=0, busy=0, msg_ready=0, configured=0. State is IDLE and the n/d/N registers are cleared.
- States: IDLE, CFG_LEAD, CFG_SHIFT, CFG_TAIL, GAP, READY, BIT_HI, BIT_LO.
- IDLE or READY with cfg_start=1:
  - latch cfg_n, cfg_d and cfg_N;
  - go to CFG_LEAD.
- Configuration sequence:
  - CFG_LEAD: one cycle, mode=1, str=0.
  - CFG_SHIFT: 4+2·KEY_LEN cycles, mode=1, str = n[3..0], then d[K-1..0], then N[K-1..0].
  - CFG_TAIL: one cycle, mode=1, str=0.
  - GAP: GAP cycles, mode=0, str=0. Then set configured=1 and go to READY.
- READY: msg_ready=1, str=0.
  - On a handshake, latch msg_data and load bit counter = n.
  - Send bits n-1..0, then one trailer bit encoded as 0, so SAM sees the rising edge that closes bit 0.
- Per bit:
  - BIT_HI: str=1 for ONE_HI or ZERO_HI cycles.
  - BIT_LO: str=0 for ONE_LO or ZERO_LO cycles.
- After the trailer bit, enter GAP, then return to READY.
- msg_ready is 0 outside READY. msg_valid is ignored before configured=1.
- n=0: the handshake produces only the trailer bit, then GAP.
- cfg_start arriving with msg_valid in READY: cfg_start wins and no handshake occurs.
- cfg_start in any other state is ignored. A later reconfiguration fully replaces n, d and N.
- reset asserted mid-operation: outputs and state return to reset values immediately. configured is cleared.

## Timing
- cfg_start sampled at edge T:
  - mode=1 during cycles T+1 … T+6+2·KEY_LEN;
  - first n bit on str during cycle T+2;
  - configured=1 in cycle T+7+2·KEY_LEN+GAP.
- Handshake at edge T: str rises at T+1.
- Message length is (n+1)·bit period + GAP cycles.
  - Bit period is ONE_HI+ONE_LO for a 1 and ZERO_HI+ZERO_LO for a 0.
  - READY is re-entered exactly that many cycles after T+1.
- Durations are counted with a 5-bit down-counter.
  - Each duration must be between 1 and 31.
  - ONE_HI > ONE_LO and ZERO_LO > ZERO_HI are required; elaboration fails otherwise.
- Outputs are registered with no combinational input-to-output path. The exception is msg_ready, which is a function of state only.

## Structure
- Shared package sam_pkg holds:
  - the state enum;
  - the n width constant (4);
  - the default duration constants;
  - the duration-counter width (5).
- Sub-module sam_pw_bit:
  - inputs: start, bit value, and four durations;
  - outputs: str_bit, done;
  - owns the BIT_HI/BIT_LO counter.
- The top level owns the configuration shifter, the message shift register and the bit counter.

## Test plan
- Config with n=3, d=8'hA5, N=8'h3C, K=8 → str during the 20 mode-high bit cycles = 0011_10100101_00111100. mode is high for exactly 22 cycles, then 2 cycles low with str=0, then configured=1.
- After config, send msg_data=3'b101 → str pattern is 12H 6L, 6H 12L, 12H 6L, then trailer 6H 12L, then GAP. msg_ready returns 1 exactly 74 cycles after str first rises.
- msg_valid=1 before any configuration → msg_ready stays 0 and str stays 0 for 100 cycles.
- In READY, assert cfg_start and msg_valid in the same cycle → configuration runs and no message bits are sent.
- Assert reset low mid-BIT_HI → str=0, mode=0, configured=0 asynchronously, before the next edge. After release, msg_valid is ignored until reconfigured.
- n=0 → the message is a single trailer (6H 12L) and GAP, then READY.
